// File: rtl/strobe_generator_pkg.sv
// strobe_generator_pkg
//   Shared types and parameter defaults for the strobe generator:
//   FSM state encoding and default widths / reset period.
package strobe_generator_pkg;

  localparam int DEF_PERIOD_WIDTH   = 16;
  localparam int DEF_BURST_WIDTH    = 16;
  localparam int DEF_DEFAULT_PERIOD = 99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } strobe_state_t;

endpackage

// File: rtl/strobe_divider.sv
// strobe_divider
//   Period counter plus the active/pending period registers and the
//   period_data valid/ready handshake.
// Ports:
//   clock, sync_reset     : clock, synchronous active-high reset
//   run                   : FSM is in RUN (counting enabled)
//   restart               : FSM is entering RUN this edge (clear div)
//   period_data/valid     : new period offer
//   period_ready          : pending slot empty
//   strobe                : one-cycle pulse when div reaches the active period
module strobe_divider
  import strobe_generator_pkg::*;
#(
  parameter int PERIOD_WIDTH   = DEF_PERIOD_WIDTH,
  parameter int DEFAULT_PERIOD = DEF_DEFAULT_PERIOD
) (
  input  logic                    clock,
  input  logic                    sync_reset,
  input  logic                    run,
  input  logic                    restart,
  input  logic [PERIOD_WIDTH-1:0] period_data,
  input  logic                    period_valid,
  output logic                    period_ready,
  output logic                    strobe
);

  localparam logic [PERIOD_WIDTH-1:0] ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  logic [PERIOD_WIDTH-1:0] div_q, div_d;
  logic [PERIOD_WIDTH-1:0] period_active_q, period_active_d;
  logic [PERIOD_WIDTH-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic                    accept, apply;

  assign strobe       = run && (div_q == period_active_q);
  assign period_ready = !pending_valid_q;
  assign accept       = period_valid && !pending_valid_q;
  // Outside RUN the pending value lands on the next edge; inside RUN only on
  // a strobe edge so the interval in flight keeps its length.
  assign apply        = pending_valid_q && (!run || strobe);

  always_comb begin
    div_d           = div_q;
    period_active_d = period_active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;

    if (restart)  div_d = '0;
    else if (run) div_d = strobe ? '0 : div_q + ONE;

    // accept requires !pending_valid, apply requires pending_valid: exclusive
    if (accept) begin
      pending_d       = period_data;
      pending_valid_d = 1'b1;
    end else if (apply) begin
      period_active_d = pending_q;
      pending_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      div_q           <= '0;
      period_active_q <= PERIOD_WIDTH'(DEFAULT_PERIOD);
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      div_q           <= div_d;
      period_active_q <= period_active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end

endmodule

// File: rtl/strobe_generator.sv
// strobe_generator
//   Programmable clock-enable strobe source. One-cycle strobe every
//   period+1 cycles while running, continuous or for a fixed burst.
//   Build option: define STROBE_GENERATOR_BURST_EN to include burst
//   counting; otherwise every run is continuous and ends only on stop.
// Ports:
//   clock, sync_reset          : clock, synchronous active-high reset
//   period_data/valid/ready    : period update handshake
//   start, burst_count, stop   : run control (burst_count 0 = continuous)
//   strobe, busy, done         : enable pulse, RUN flag, end-of-run pulse
module strobe_generator
  import strobe_generator_pkg::*;
#(
  parameter int PERIOD_WIDTH   = DEF_PERIOD_WIDTH,
  parameter int BURST_WIDTH    = DEF_BURST_WIDTH,
  parameter int DEFAULT_PERIOD = DEF_DEFAULT_PERIOD
) (
  input  logic                    clock,
  input  logic                    sync_reset,
  input  logic [PERIOD_WIDTH-1:0] period_data,
  input  logic                    period_valid,
  output logic                    period_ready,
  input  logic                    start,
  input  logic [BURST_WIDTH-1:0]  burst_count,
  input  logic                    stop,
  output logic                    strobe,
  output logic                    busy,
  output logic                    done
);

  strobe_state_t state_q, state_d;
  logic          run, restart, last_strobe;

  assign run  = (state_q == RUN);
  assign busy = run;
  assign done = (state_q == DONE);

  strobe_divider #(
    .PERIOD_WIDTH  (PERIOD_WIDTH),
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) u_div (
    .clock       (clock),
    .sync_reset  (sync_reset),
    .run         (run),
    .restart     (restart),
    .period_data (period_data),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .strobe      (strobe)
  );

`ifdef STROBE_GENERATOR_BURST_EN
  localparam logic [BURST_WIDTH-1:0] BONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

  logic [BURST_WIDTH-1:0] burst_latched_q, burst_latched_d;
  logic [BURST_WIDTH-1:0] sent_q, sent_d;

  always_comb begin
    burst_latched_d = burst_latched_q;
    sent_d          = sent_q;
    if (restart) begin
      burst_latched_d = burst_count;
      sent_d          = '0;
    end else if (strobe) begin
      sent_d = sent_q + BONE;
    end
  end

  // burst_latched == 0 is continuous mode and never terminates itself
  assign last_strobe = strobe && (burst_latched_q != '0) &&
                       (sent_q == burst_latched_q - BONE);

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      burst_latched_q <= '0;
      sent_q          <= '0;
    end else begin
      burst_latched_q <= burst_latched_d;
      sent_q          <= sent_d;
    end
  end
`else
  logic unused_burst;
  assign unused_burst = ^burst_count;
  assign last_strobe  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    unique case (state_q)
      IDLE: if (start && !stop) begin
        state_d = RUN;
        restart = 1'b1;
      end
      RUN:  if (stop || last_strobe) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sync_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

endmodule

// File: doc/strobe_generator.md
# strobe_generator

Programmable clock-enable strobe source for the timing chain. Emits a one-cycle `strobe` every `period+1` clock cycles, either continuously or for a fixed burst, and drives the `clock_enable` input of downstream counters. Period changes arrive over a valid/ready handshake and take effect only at a strobe boundary, so the output cadence never glitches.

## Interface
- `PERIOD_WIDTH`, 16: width of the period value.
- `BURST_WIDTH`, 16: width of the burst length.
- `DEFAULT_PERIOD`, 99: active period after reset; strobe spacing is 100 cycles.
- `clock` in 1: single clock; all logic on its rising edge.
- `sync_reset` in 1: synchronous, active-high reset.
- `period_data` in PERIOD_WIDTH: new period value N; strobe spacing is N+1 cycles.
- `period_valid` in 1: `period_data` is valid.
- `period_ready` out 1: pending slot is empty; transfer occurs when valid && ready.
- `start` in 1: begin a run. Ignored unless the FSM is in IDLE.
- `burst_count` in BURST_WIDTH: number of strobes per run, latched on `start`. 0 selects continuous mode.
- `stop` in 1: abort a run.
- `strobe` out 1: one-cycle enable pulse.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- FSM states:
  - IDLE to RUN on `start`.
  - RUN to DONE when the last burst strobe completes, or on `stop`.
  - DONE to IDLE unconditionally after one cycle.
- Divider:
  - `div` counts 0..`period_active`.
  - Counting is enabled only in RUN.
  - `div` wraps to 0 in the cycle after a strobe.
  - `div` is forced to 0 on entry to RUN.
- `strobe = (state==RUN) && (div==period_active)`. This is combinational from registers. A period of 0 gives a strobe on every RUN cycle.
- Burst:
  - `burst_latched` is loaded on `start`. `sent` is cleared on `start`.
  - `sent` increments on each strobe.
  - A strobe with `sent == burst_latched-1` is the last one; its edge moves the FSM to DONE.
  - Continuous mode (`burst_latched == 0`) never self-terminates.
- Period handshake:
  - One-entry pending register. `period_ready = !pending_valid`.
  - The pending value is applied to `period_active`:
    - at the next edge while in IDLE or DONE;
    - on the `start` edge;
    - in RUN, only on an edge where `strobe` is high.
  - Applying clears `pending_valid`.
- Simultaneous events:
  - `start` and `stop` together in IDLE: `stop` wins and the FSM stays in IDLE.
  - `stop` in the same cycle as a strobe: that strobe is already visible and counts. The FSM then moves to DONE and no further strobes occur.
  - Last burst strobe and `stop` in the same cycle: single `done`.
  - A handshake transfer and a pending apply cannot coincide, because ready is low while pending.
- Reset values, which also apply when `sync_reset` is asserted mid-run:
  - state IDLE, `div`=0, `sent`=0, `burst_latched`=0.
  - `period_active`=`DEFAULT_PERIOD`, `pending_valid`=0.
  - `strobe`=0, `busy`=0, `done`=0, `period_ready`=1.
  - A run in progress is dropped without a `done`.

## Timing
- `start` sampled at edge t:
  - `busy`=1 from cycle t+1.
  - First strobe in cycle t+1+P.
  - Strobes repeat every P+1 cycles.
- Last strobe in cycle s: `busy`=0 and `done`=1 in cycle s+1; IDLE in s+2.
- `stop` sampled at edge t in RUN: `done`=1 and `busy`=0 in cycle t+1.
- Handshake:
  - A period accepted at edge t in IDLE is active from cycle t+2.
  - `period_ready` returns high in cycle t+2.
  - In RUN, the new period applies to the interval starting after the next strobe.
- `strobe`, `busy`, `done`: zero added latency beyond the registered state.

## Configuration
- `STROBE_GENERATOR_BURST_EN` defined: burst logic is present as described above.
- Not defined:
  - The `burst_count` port remains but is ignored.
  - `sent` and `burst_latched` are not built.
  - Every run is continuous and ends only on `stop`.
  - `done` still pulses after `stop`.

## Structure
- Package `strobe_generator_pkg` holds:
  - typedef `strobe_state_t` with IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - localparam defaults for `PERIOD_WIDTH`, `BURST_WIDTH` and `DEFAULT_PERIOD`.
- Sub-module `strobe_divider`:
  - contains `div`, the comparator and the `period_active`/pending registers with the handshake;
  - takes inputs `run` and `restart` from the FSM;
  - returns `strobe`.

## Test plan
- Reset, then `start`, `burst_count`=3, default period: strobes at cycles t+100, t+200, t+300; `done` at t+301; `busy` low from t+301.
- Period 0, `burst_count`=0: `strobe` high every RUN cycle; `stop` at edge u gives `done` at u+1 and no strobe from u+1 onward.
- In RUN with P=9, `period_data`=4 accepted mid-interval:
  - `period_ready` stays low until the next strobe;
  - spacing is 10 for the current interval, then 5.
- `start` and `stop` in the same IDLE cycle: no `busy`, no `strobe`, no `done`.
- `sync_reset` during burst 2 of 5: all outputs reach reset values the next cycle, `period_active`=99, no `done`.
- Build without `STROBE_GENERATOR_BURST_EN`, `burst_count`=2: strobes continue past 2 until `stop`.
